// File: rtl/axis_exp_adc_pkg.sv
// Shared types and constants for the ADC sequencer slice.
package axis_exp_adc_pkg;

    localparam int DataWidth = 32;

    // Sequencer FSM encoding.
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ARM   = 3'd1,
        RUN   = 3'd2,
        DRAIN = 3'd3,
        DONE  = 3'd4
    } seq_state_t;

    // Register-write command that takes the ADC out of register-access mode.
    localparam logic [DataWidth-1:0] ExitReg = 32'hFF00_0000;

endpackage

// File: rtl/axis_cmd_rr_arbiter.sv
// Two-input round-robin command arbiter with a one-entry holding register
// feeding an AXI-Stream output. Grants only when enabled and the holding
// register is empty.
module axis_cmd_rr_arbiter
    import axis_exp_adc_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic [DataWidth-1:0] s0_tdata,
    input  logic                 s0_tvalid,
    output logic                 s0_tready,
    input  logic [DataWidth-1:0] s1_tdata,
    input  logic                 s1_tvalid,
    output logic                 s1_tready,
    output logic [DataWidth-1:0] m_tdata,
    output logic                 m_tvalid,
    input  logic                 m_tready
);

    // Last granted requester: 0 = s0, 1 = s1. A tie goes to the other one.
    logic rr_ptr;
    logic gnt0;
    logic gnt1;

    // Pick at most one requester when the holding register is free.
    always_comb begin
        // NOTE: every combinational output gets a default first; a path that
        // leaves one unassigned would infer a latch.
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (en && !m_tvalid) begin
            if (s0_tvalid && s1_tvalid) begin
                gnt0 = rr_ptr;
                gnt1 = !rr_ptr;
            end else begin
                gnt0 = s0_tvalid;
                gnt1 = s1_tvalid;
            end
        end
    end

    assign s0_tready = gnt0;
    assign s1_tready = gnt1;

    // Holding register: load on grant, empty on downstream handshake.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values of its inputs.
        if (rst) begin
            m_tvalid <= 1'b0;
            m_tdata  <= '0;
            rr_ptr   <= 1'b0;
        end else if (gnt0) begin
            m_tvalid <= 1'b1;
            m_tdata  <= s0_tdata;
            rr_ptr   <= 1'b0;
        end else if (gnt1) begin
            m_tvalid <= 1'b1;
            m_tdata  <= s1_tdata;
            rr_ptr   <= 1'b1;
        end else if (m_tvalid && m_tready) begin
            m_tvalid <= 1'b0;
            m_tdata  <= '0;
        end
    end

endmodule

// File: rtl/axis_exp_adc_sequencer.sv
// ADC acquisition sequencer: periodic conversion triggers for a programmed
// number of samples, sample tracking on the ADC output stream, and gating of
// register-write commands onto the ADC command stream while idle.
module axis_exp_adc_sequencer
    import axis_exp_adc_pkg::*;
#(
    parameter int CNT_WIDTH  = 32,
    parameter int MIN_PERIOD = 16
) (
    input  logic                 aclk,
    input  logic                 areset,
    input  logic [CNT_WIDTH-1:0] cfg_period,
    input  logic [CNT_WIDTH-1:0] cfg_num_samples,
    input  logic                 start,
    input  logic                 stop,
    input  logic                 adc_csn,
    output logic                 trigger,
    input  logic                 mon_tvalid,
    input  logic                 mon_tready,
    input  logic [DataWidth-1:0] s0_axis_tdata,
    input  logic                 s0_axis_tvalid,
    output logic                 s0_axis_tready,
    input  logic [DataWidth-1:0] s1_axis_tdata,
    input  logic                 s1_axis_tvalid,
    output logic                 s1_axis_tready,
    output logic [DataWidth-1:0] m_axis_tdata,
    output logic                 m_axis_tvalid,
    input  logic                 m_axis_tready,
    output logic                 busy,
    output logic                 done,
    output logic [CNT_WIDTH-1:0] overrun_cnt
);

    localparam logic [CNT_WIDTH-1:0] CntOne    = CNT_WIDTH'(1);
    localparam logic [CNT_WIDTH-1:0] MinPeriod = CNT_WIDTH'(MIN_PERIOD);

    seq_state_t state;
    seq_state_t state_next;

    logic [CNT_WIDTH-1:0] period_reg;
    logic [CNT_WIDTH-1:0] num_reg;
    logic [CNT_WIDTH-1:0] period_cnt;
    logic [CNT_WIDTH-1:0] issued;
    logic [CNT_WIDTH-1:0] received;
    logic [CNT_WIDTH-1:0] received_next;

    logic hold_full;
    logic start_ok;
    logic slot;
    logic fire;
    logic skip;
    logic mon_hs;

    // Holding register full means a command is still owed to the ADC; an
    // acquisition must not start underneath it.
    assign hold_full     = m_axis_tvalid;
    assign start_ok      = start && !hold_full && adc_csn;
    assign slot          = (state == RUN) && (period_cnt == '0);
    assign mon_hs        = mon_tvalid && mon_tready && (state inside {ARM, RUN, DRAIN});
    assign received_next = mon_hs ? received + CntOne : received;
    assign busy          = (state != IDLE);

    axis_cmd_rr_arbiter u_arb (
        .clk       (aclk),
        .rst       (areset),
        .en        (state == IDLE),
        .s0_tdata  (s0_axis_tdata),
        .s0_tvalid (s0_axis_tvalid),
        .s0_tready (s0_axis_tready),
        .s1_tdata  (s1_axis_tdata),
        .s1_tvalid (s1_axis_tvalid),
        .s1_tready (s1_axis_tready),
        .m_tdata   (m_axis_tdata),
        .m_tvalid  (m_axis_tvalid),
        .m_tready  (m_axis_tready)
    );

    // FSM state register.
    always_ff @(posedge aclk) begin
        if (areset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode plus trigger/done pulses and counter strobes.
    always_comb begin
        state_next = state;
        trigger    = 1'b0;
        done       = 1'b0;
        fire       = 1'b0;
        skip       = 1'b0;
        case (state)
            IDLE: begin
                if (start_ok) begin
                    state_next = ARM;
                end
            end
            ARM: begin
                state_next = RUN;
            end
            RUN: begin
                // stop wins over a trigger slot in the same cycle.
                if (stop) begin
                    state_next = DRAIN;
                end else if (slot) begin
                    if (adc_csn) begin
                        trigger = 1'b1;
                        fire    = 1'b1;
                        if ((num_reg != '0) && (issued + CntOne == num_reg)) begin
                            state_next = DRAIN;
                        end
                    end else begin
                        skip = 1'b1;
                    end
                end
            end
            DRAIN: begin
                // Include a handshake landing this cycle so done follows it directly.
                if ((received_next >= issued) && adc_csn) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Acquisition configuration, period timer and sample/overrun counters.
    always_ff @(posedge aclk) begin
        if (areset) begin
            period_reg  <= '0;
            num_reg     <= '0;
            period_cnt  <= '0;
            issued      <= '0;
            received    <= '0;
            overrun_cnt <= '0;
        end else if ((state == IDLE) && start_ok) begin
            period_reg  <= (cfg_period < MinPeriod) ? MinPeriod : cfg_period;
            num_reg     <= cfg_num_samples;
            issued      <= '0;
            received    <= '0;
            overrun_cnt <= '0;
        end else begin
            if (state == ARM) begin
                period_cnt <= period_reg - CntOne;
            end else if (state == RUN) begin
                period_cnt <= (period_cnt == '0) ? period_reg - CntOne : period_cnt - CntOne;
            end
            if (fire) begin
                issued <= issued + CntOne;
            end
            if (skip && (overrun_cnt != '1)) begin
                overrun_cnt <= overrun_cnt + CntOne;
            end
            received <= received_next;
        end
    end

endmodule

// File: tb/tb_axis_exp_adc_sequencer.sv
// Directed testbench for axis_exp_adc_sequencer. Inputs change 1 time unit
// after the rising edge; outputs are sampled on the falling edge.
module tb_axis_exp_adc_sequencer;

    logic        aclk = 1'b0;
    logic        areset;
    logic [31:0] cfg_period;
    logic [31:0] cfg_num_samples;
    logic        start;
    logic        stop;
    logic        adc_csn;
    logic        trigger;
    logic        mon_tvalid;
    logic        mon_tready;
    logic [31:0] s0_axis_tdata;
    logic        s0_axis_tvalid;
    logic        s0_axis_tready;
    logic [31:0] s1_axis_tdata;
    logic        s1_axis_tvalid;
    logic        s1_axis_tready;
    logic [31:0] m_axis_tdata;
    logic        m_axis_tvalid;
    logic        m_axis_tready;
    logic        busy;
    logic        done;
    logic [31:0] overrun_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    // ADC model timing: csn low for conv_len cycles after a trigger, sample
    // delivered samp_delay cycles after the trigger.
    int conv_len   = 10;
    int samp_delay = 12;

    int          trig_at[$];
    logic [31:0] got[$];
    logic [31:0] ovr_log [0:199];
    int          done_at;
    int          done_cnt;
    int          idle_at;
    int          ready_at;
    int          viol;
    int          a_idx;
    int          b_idx;
    logic        sent;

    logic [31:0] a_words   [4] = '{32'hA000_0000, 32'hA000_0001, 32'hA000_0002, 32'hA000_0003};
    logic [31:0] b_words   [4] = '{32'hB000_0000, 32'hB000_0001, 32'hB000_0002, 32'hB000_0003};
    logic [31:0] exp_order [8] = '{32'hB000_0000, 32'hA000_0000, 32'hB000_0001, 32'hA000_0001,
                                   32'hB000_0002, 32'hA000_0002, 32'hB000_0003, 32'hA000_0003};

    always #5 aclk = ~aclk;

    axis_exp_adc_sequencer #(
        .CNT_WIDTH  (32),
        .MIN_PERIOD (16)
    ) dut (
        .aclk            (aclk),
        .areset          (areset),
        .cfg_period      (cfg_period),
        .cfg_num_samples (cfg_num_samples),
        .start           (start),
        .stop            (stop),
        .adc_csn         (adc_csn),
        .trigger         (trigger),
        .mon_tvalid      (mon_tvalid),
        .mon_tready      (mon_tready),
        .s0_axis_tdata   (s0_axis_tdata),
        .s0_axis_tvalid  (s0_axis_tvalid),
        .s0_axis_tready  (s0_axis_tready),
        .s1_axis_tdata   (s1_axis_tdata),
        .s1_axis_tvalid  (s1_axis_tvalid),
        .s1_axis_tready  (s1_axis_tready),
        .m_axis_tdata    (m_axis_tdata),
        .m_axis_tvalid   (m_axis_tvalid),
        .m_axis_tready   (m_axis_tready),
        .busy            (busy),
        .done            (done),
        .overrun_cnt     (overrun_cnt)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Drive phase of the next cycle.
    task automatic cyc();
        @(posedge aclk);
        #1;
    endtask

    function automatic logic [31:0] trig_q(input int k);
        return (k < trig_at.size()) ? 32'(trig_at[k]) : 32'hFFFF_FFFF;
    endfunction

    function automatic logic [31:0] got_q(input int k);
        return (k < got.size()) ? got[k] : 32'hDEAD_DEAD;
    endfunction

    // Pulse start with the given configuration; the start cycle is cycle 0.
    task automatic launch(input logic [31:0] period, input logic [31:0] num);
        cyc();
        cfg_period      = period;
        cfg_num_samples = num;
        start           = 1'b1;
        @(negedge aclk);
    endtask

    // Observe n cycles after launch, optionally pulsing stop in cycle stop_at.
    task automatic watch(input int n, input int stop_at);
        trig_at.delete();
        done_at  = -1;
        done_cnt = 0;
        idle_at  = -1;
        for (int i = 1; i <= n; i++) begin
            cyc();
            start = 1'b0;
            stop  = (i == stop_at);
            @(negedge aclk);
            if (trigger === 1'b1) trig_at.push_back(i);
            if (done === 1'b1) begin
                done_cnt++;
                if (done_at < 0) done_at = i;
            end
            if ((busy !== 1'b1) && (idle_at < 0)) idle_at = i;
            ovr_log[i] = overrun_cnt;
        end
    endtask

    // ADC model: reacts to each trigger with a conversion and one sample.
    initial begin
        adc_csn    = 1'b1;
        mon_tvalid = 1'b0;
        forever begin
            @(negedge aclk);
            if (trigger === 1'b1) begin
                @(posedge aclk);
                #1;
                adc_csn = 1'b0;
                repeat (conv_len) begin
                    @(posedge aclk);
                    #1;
                end
                adc_csn = 1'b1;
                repeat (samp_delay - conv_len - 1) begin
                    @(posedge aclk);
                    #1;
                end
                mon_tvalid = 1'b1;
                @(posedge aclk);
                #1;
                mon_tvalid = 1'b0;
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, observed timeout, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        areset          = 1'b1;
        cfg_period      = '0;
        cfg_num_samples = '0;
        start           = 1'b0;
        stop            = 1'b0;
        mon_tready      = 1'b1;
        s0_axis_tdata   = '0;
        s0_axis_tvalid  = 1'b0;
        s1_axis_tdata   = '0;
        s1_axis_tvalid  = 1'b0;
        m_axis_tready   = 1'b0;

        // Reset values.
        cyc();
        cyc();
        @(negedge aclk);
        check("rst_trigger", 32'(trigger), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_overrun", overrun_cnt, 32'd0);
        check("rst_m_tvalid", 32'(m_axis_tvalid), 32'd0);
        check("rst_m_tdata", m_axis_tdata, 32'd0);
        check("rst_s0_tready", 32'(s0_axis_tready), 32'd0);
        check("rst_s1_tready", 32'(s1_axis_tready), 32'd0);
        cyc();
        areset = 1'b0;

        // Arbitration: both requesters always valid, output stalled 4 cycles.
        a_idx = 0;
        b_idx = 0;
        viol  = 0;
        got.delete();
        for (int i = 0; i < 40; i++) begin
            cyc();
            s0_axis_tvalid = (a_idx < 4);
            s0_axis_tdata  = (a_idx < 4) ? a_words[a_idx] : 32'h0;
            s1_axis_tvalid = (b_idx < 4);
            s1_axis_tdata  = (b_idx < 4) ? b_words[b_idx] : 32'h0;
            m_axis_tready  = (i >= 4);
            @(negedge aclk);
            if (m_axis_tvalid && (s0_axis_tready || s1_axis_tready)) viol++;
            if (s0_axis_tready) a_idx++;
            if (s1_axis_tready) b_idx++;
            if (m_axis_tvalid && m_axis_tready) got.push_back(m_axis_tdata);
        end
        check("arb_no_grant_while_held", 32'(viol), 32'd0);
        check("arb_word_count", 32'(got.size()), 32'd8);
        for (int k = 0; k < 8; k++) begin
            check($sformatf("arb_order_%0d", k), got_q(k), exp_order[k]);
        end
        check("arb_drained", 32'(m_axis_tvalid), 32'd0);

        // Normal acquisition: period 20, 3 samples.
        conv_len   = 10;
        samp_delay = 12;
        launch(32'd20, 32'd3);
        watch(80, 0);
        check("norm_trig_count", 32'(trig_at.size()), 32'd3);
        check("norm_trig_0", trig_q(0), 32'd21);
        check("norm_trig_1", trig_q(1), 32'd41);
        check("norm_trig_2", trig_q(2), 32'd61);
        check("norm_done_at", 32'(done_at), 32'd74);
        check("norm_done_count", 32'(done_cnt), 32'd1);
        check("norm_idle_at", 32'(idle_at), 32'd75);
        check("norm_overrun", overrun_cnt, 32'd0);

        // Period clamp and overrun: period 4 -> 16, conversion 20 cycles.
        conv_len   = 20;
        samp_delay = 21;
        launch(32'd4, 32'd3);
        watch(110, 0);
        check("clamp_trig_count", 32'(trig_at.size()), 32'd3);
        check("clamp_trig_0", trig_q(0), 32'd17);
        check("clamp_trig_1", trig_q(1), 32'd49);
        check("clamp_trig_2", trig_q(2), 32'd81);
        check("clamp_ovr_before_skip", ovr_log[33], 32'd0);
        check("clamp_ovr_after_skip1", ovr_log[34], 32'd1);
        check("clamp_ovr_after_skip2", ovr_log[66], 32'd2);
        check("clamp_overrun_final", overrun_cnt, 32'd2);
        check("clamp_done_at", 32'(done_at), 32'd103);
        check("clamp_idle_at", 32'(idle_at), 32'd104);

        // Continuous mode, stop on the slot after the fifth trigger.
        conv_len   = 10;
        samp_delay = 12;
        launch(32'd20, 32'd0);
        watch(130, 121);
        check("cont_trig_count", 32'(trig_at.size()), 32'd5);
        check("cont_trig_4", trig_q(4), 32'd101);
        check("cont_done_at", 32'(done_at), 32'd123);
        check("cont_done_count", 32'(done_cnt), 32'd1);
        check("cont_idle_at", 32'(idle_at), 32'd124);
        check("cont_overrun", overrun_cnt, 32'd0);

        // Command gating: s0 waits through a run; start with a held word is ignored.
        launch(32'd20, 32'd1);
        viol     = 0;
        ready_at = -1;
        for (int i = 1; i <= 40; i++) begin
            cyc();
            start          = 1'b0;
            s0_axis_tvalid = (ready_at < 0);
            s0_axis_tdata  = 32'hC0DE_0001;
            m_axis_tready  = 1'b0;
            @(negedge aclk);
            if (busy && s0_axis_tready) viol++;
            if (!busy && s0_axis_tready && (ready_at < 0)) ready_at = i;
        end
        check("gate_no_grant_busy", 32'(viol), 32'd0);
        check("gate_grant_at", 32'(ready_at), 32'd35);
        cyc();
        start = 1'b1;
        @(negedge aclk);
        check("gate_held_at_start", 32'(m_axis_tvalid), 32'd1);
        cyc();
        start = 1'b0;
        @(negedge aclk);
        check("gate_start_ignored", 32'(busy), 32'd0);
        cyc();
        @(negedge aclk);
        check("gate_still_idle", 32'(busy), 32'd0);
        check("gate_held_data", m_axis_tdata, 32'hC0DE_0001);
        cyc();
        m_axis_tready = 1'b1;
        @(negedge aclk);
        cyc();
        @(negedge aclk);
        check("gate_released", 32'(m_axis_tvalid), 32'd0);

        // Reset mid-RUN after two triggers, with a command pending upstream.
        conv_len   = 20;
        samp_delay = 21;
        launch(32'd4, 32'd0);
        trig_at.delete();
        for (int i = 1; i <= 55; i++) begin
            cyc();
            start          = 1'b0;
            s0_axis_tvalid = 1'b1;
            s0_axis_tdata  = 32'hD00D_0002;
            @(negedge aclk);
            if (trigger === 1'b1) trig_at.push_back(i);
        end
        check("mrst_trig_count", 32'(trig_at.size()), 32'd2);
        check("mrst_ovr_before", overrun_cnt, 32'd1);
        cyc();
        areset = 1'b1;
        @(negedge aclk);
        cyc();
        areset = 1'b0;
        @(negedge aclk);
        check("mrst_trigger", 32'(trigger), 32'd0);
        check("mrst_busy", 32'(busy), 32'd0);
        check("mrst_m_tvalid", 32'(m_axis_tvalid), 32'd0);
        check("mrst_overrun", overrun_cnt, 32'd0);
        sent = s0_axis_tready;
        viol = 0;
        got.delete();
        for (int i = 0; i < 40; i++) begin
            cyc();
            s0_axis_tvalid = !sent;
            @(negedge aclk);
            if (s0_axis_tready) sent = 1'b1;
            if (trigger || busy || done) viol++;
            if (m_axis_tvalid && m_axis_tready) got.push_back(m_axis_tdata);
        end
        check("mrst_stays_idle", 32'(viol), 32'd0);
        check("mrst_cmd_count", 32'(got.size()), 32'd1);
        check("mrst_cmd_data", got_q(0), 32'hD00D_0002);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
